lsu_bus: RTL and testbench

// - Load/store unit for the MA stage of the multi-cycle RV32 core. It sits downstream of the ALU address path.
// - Takes one access request per instruction and decodes it to a byte-addressed data BRAM or to the UART MMIO registers.
// - Performs RV32I lane shifting and load sign extension.
// - Holds memWait high until the access completes, so the stage sequencer stalls.

---
 rtl/lsu_bus_if.sv | 23 ++
 rtl/lsu_bus.sv | 216 +++++++++++++++++++++
 tb/tb_lsu_bus.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_if.sv
// Request/response bundle between the MA-stage sequencer and the load/store unit.
// The sequencer is the master; the LSU is the slave.
interface lsu_bus_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] vaddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        fault;
    logic        memWait;

    modport master (
        output req, we, funct3, vaddr, wdata,
        input  rdata, done, fault, memWait
    );

    modport slave (
        input  req, we, funct3, vaddr, wdata,
        output rdata, done, fault, memWait
    );
endinterface

// File: rtl/lsu_bus.sv
// RV32I load/store unit: decodes accesses to a byte-lane data BRAM or to UART MMIO registers,
// aligns and extends load data, and stalls the sequencer until each access completes.
module lsu_bus #(
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] UART_BASE  = 32'h1000_0000,
    parameter int unsigned BAUD_DIV   = 434
) (
    input  logic     CLK,
    input  logic     RST,
    lsu_bus_if.slave bus,
    output logic     uart_txd
);
    localparam int unsigned AW         = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);
    localparam int unsigned BW         = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {StIdle, StDrd, StResp, StUwait} state_e;

    state_e      state_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        fault_q;
    logic        wait_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [7:0]  txb_q;

    // Request decode, valid while the FSM is idle.
    logic        is_word;
    logic        is_half;
    logic        misaligned;
    logic        in_dmem;
    logic        is_txdata;
    logic        is_status;
    logic [3:0]  be_base;
    logic [3:0]  be;
    logic [31:0] wd;

    always_comb begin
        is_word    = bus.funct3[1];
        is_half    = !bus.funct3[1] && bus.funct3[0];
        misaligned = (is_half && bus.vaddr[0]) || (is_word && (bus.vaddr[1:0] != 2'b00));
        in_dmem    = bus.vaddr < DMEM_BYTES;
        is_txdata  = bus.vaddr == UART_BASE;
        is_status  = bus.vaddr == (UART_BASE + 32'd4);
        if (is_word) begin
            be_base = 4'b1111;
        end else if (is_half) begin
            be_base = 4'b0011;
        end else begin
            be_base = 4'b0001;
        end
        be = be_base << bus.vaddr[1:0];
        wd = bus.wdata << {bus.vaddr[1:0], 3'b000};
    end

    // Data BRAM: no reset so it maps onto block RAM and keeps contents across RST.
    logic [31:0]   mem [DMEM_WORDS];
    logic [31:0]   ram_q;
    logic [AW-1:0] widx;
    logic          acc_ok;
    logic          mem_we;
    logic          mem_re;

    assign widx   = bus.vaddr[AW+1:2];
    assign acc_ok = !RST && (state_q == StIdle) && bus.req && !misaligned && in_dmem;
    assign mem_we = acc_ok && bus.we;
    assign mem_re = acc_ok && !bus.we;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][i*8 +: 8] <= wd[i*8 +: 8];
                end
            end
        end
        if (mem_re) begin
            ram_q <= mem[widx];
        end
    end

    // Lane select and extension for the word returned by the BRAM.
    logic [31:0] lane;
    logic [31:0] ld_val;

    always_comb begin
        lane = ram_q >> {off_q, 3'b000};
        if (f3_q[1]) begin
            ld_val = ram_q;
        end else if (f3_q[0]) begin
            ld_val = {{16{~f3_q[2] & lane[15]}}, lane[15:0]};
        end else begin
            ld_val = {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
        end
    end

    // UART transmitter, 8N1.
    logic          tx_busy_q;
    logic [3:0]    tx_bit_q;
    logic [BW-1:0] tx_baud_q;
    logic [8:0]    tx_sh_q;
    logic          txd_q;
    logic          tx_tick;
    logic          tx_free;
    logic          tx_start;
    logic [7:0]    tx_byte;

    assign tx_tick = tx_baud_q == BAUD_LAST;
    // Free during the last stop-bit cycle too, so a queued frame follows with no gap.
    assign tx_free = !tx_busy_q || (tx_tick && (tx_bit_q == 4'd9));
    assign tx_start = ((state_q == StIdle) && bus.req && bus.we && !misaligned && is_txdata
                       && tx_free)
                   || ((state_q == StUwait) && tx_free);
    assign tx_byte = (state_q == StUwait) ? txb_q : bus.wdata[7:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_busy_q <= 1'b0;
            tx_bit_q  <= '0;
            tx_baud_q <= '0;
            tx_sh_q   <= '0;
            txd_q     <= 1'b1;
        end else if (tx_start) begin
            tx_busy_q <= 1'b1;
            tx_bit_q  <= '0;
            tx_baud_q <= '0;
            tx_sh_q   <= {1'b1, tx_byte};
            txd_q     <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_tick) begin
                tx_baud_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    txd_q     <= 1'b1;
                end else begin
                    txd_q    <= tx_sh_q[0];
                    tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
                    tx_bit_q <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + BW'(1);
            end
        end
    end

    // Access sequencer; response outputs are registered and last exactly one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            rdata_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            wait_q  <= 1'b0;
            off_q   <= '0;
            f3_q    <= '0;
            txb_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        off_q <= bus.vaddr[1:0];
                        f3_q  <= bus.funct3;
                        txb_q <= bus.wdata[7:0];
                        if (misaligned) begin
                            state_q <= StResp;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else if (in_dmem && !bus.we) begin
                            state_q <= StDrd;
                            wait_q  <= 1'b1;
                        end else if (is_txdata && bus.we && !tx_free) begin
                            state_q <= StUwait;
                            wait_q  <= 1'b1;
                        end else begin
                            state_q <= StResp;
                            done_q  <= 1'b1;
                            if (is_status && !bus.we) begin
                                rdata_q <= {31'b0, tx_busy_q};
                            end
                        end
                    end
                end
                StDrd: begin
                    state_q <= StResp;
                    done_q  <= 1'b1;
                    wait_q  <= 1'b0;
                    rdata_q <= ld_val;
                end
                StUwait: begin
                    if (tx_free) begin
                        state_q <= StResp;
                        done_q  <= 1'b1;
                        wait_q  <= 1'b0;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.done    = done_q;
    assign bus.fault   = fault_q;
    assign bus.memWait = (state_q == StIdle) ? bus.req : wait_q;
    assign uart_txd    = txd_q;
endmodule

// File: tb/tb_lsu_bus.sv
// Bench for lsu_bus: a byte-level memory and UART frame-schedule model checked every cycle,
// plus hand-computed expectations for the key load/store and UART scenarios.
module tb_lsu_bus;
    localparam int          B  = 4;
    localparam logic [31:0] UB = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd;

    lsu_bus_if bus ();

    lsu_bus #(
        .DMEM_WORDS(1024),
        .UART_BASE (UB),
        .BAUD_DIV  (B)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .bus     (bus),
        .uart_txd(txd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state.
    logic [7:0]  mm [0:4095];
    bit          acc_valid = 0;
    int          req_cyc   = 0;
    int          done_cyc  = 0;
    logic [31:0] e_rdata;
    logic        e_fault;
    int          fr_start[$];
    logic [7:0]  fr_data[$];
    int          tx_end    = 0;
    bit          chk_en    = 0;

    logic [31:0] last_rdata;
    logic        last_fault;
    int          last_done_cyc = -1;
    logic        txd_log [0:8191];
    logic        e_done;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic exp_txd(input int c);
        logic v = 1'b1;
        for (int i = 0; i < fr_start.size(); i++) begin
            if (c >= fr_start[i] && c < fr_start[i] + 10 * B) begin
                int k = (c - fr_start[i]) / B;
                v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : fr_data[i][k-1];
            end
        end
        return v;
    endfunction

    function automatic logic busy_at(input int c);
        logic v = 1'b0;
        for (int i = 0; i < fr_start.size(); i++) begin
            if (c >= fr_start[i] && c < fr_start[i] + 10 * B) v = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] a, input int sz, input logic uns);
        logic [31:0] v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[a+i];
        if (!uns && sz == 1 && v[7]) v[31:8] = '1;
        if (!uns && sz == 2 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            e_done = acc_valid && (cyc == done_cyc);
            chk("done", bus.done, e_done);
            if (e_done) begin
                chk("fault", bus.fault, e_fault);
                chk("rdata", bus.rdata, e_rdata);
            end
            chk("memWait", bus.memWait, acc_valid && cyc >= req_cyc && cyc < done_cyc);
            chk("txd", txd, exp_txd(cyc));
        end
        if (bus.done === 1'b1) begin
            last_done_cyc = cyc;
            last_rdata    = bus.rdata;
            last_fault    = bus.fault;
        end
        if (cyc < 8192) txd_log[cyc] = txd;
    end

    // Drives one request cycle and records what the spec says must come back.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        int r;
        int sz;
        int s;
        bit mis;
        r   = cyc;
        sz  = f3[1] ? 4 : (f3[0] ? 2 : 1);
        mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        e_fault  = mis;
        e_rdata  = '0;
        done_cyc = r + 1;
        if (!mis) begin
            if (a < 32'd4096) begin
                if (w) begin
                    for (int i = 0; i < sz; i++) mm[a+i] = d[8*i +: 8];
                end else begin
                    e_rdata  = load_val(a, sz, f3[2]);
                    done_cyc = r + 2;
                end
            end else if (a == UB) begin
                if (w) begin
                    s = (r + 1 > tx_end) ? r + 1 : tx_end;
                    fr_start.push_back(s);
                    fr_data.push_back(d[7:0]);
                    tx_end   = s + 10 * B;
                    done_cyc = s;
                end
            end else if (a == UB + 32'd4) begin
                if (!w) e_rdata = {31'b0, busy_at(r)};
            end
        end
        req_cyc    = r;
        acc_valid  = 1;
        bus.req    = 1'b1;
        bus.we     = w;
        bus.funct3 = f3;
        bus.vaddr  = a;
        bus.wdata  = d;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    task automatic finish_acc();
        while (cyc <= done_cyc) begin
            @(posedge clk);
            #1;
        end
        acc_valid = 0;
    endtask

    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
        issue(w, f3, a, d);
        finish_acc();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        acc_valid = 0;
        fr_start.delete();
        fr_data.delete();
        tx_end = 0;
        @(negedge clk);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_memwait", bus.memWait, 1'b0);
        chk("rst_txd", txd, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int s1;
        int r2;
        logic [9:0] pat;
        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.funct3 = 3'b000;
        bus.vaddr  = '0;
        bus.wdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_fault", bus.fault, 1'b0);
        chk("reset_rdata", bus.rdata, 32'h0);
        chk("reset_memwait", bus.memWait, 1'b0);
        chk("reset_txd", txd, 1'b1);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1;
        idle(2);

        // Word store/load and latencies.
        access(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        chk("sw_latency", 32'(last_done_cyc - req_cyc), 32'd1);
        access(1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_latency", 32'(last_done_cyc - req_cyc), 32'd2);
        chk("lw_10", last_rdata, 32'hDEAD_BEEF);

        // Byte store with sign/zero extension.
        access(1'b1, 3'b000, 32'h13, 32'h0000_0080);
        access(1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_13", last_rdata, 32'hFFFF_FF80);
        access(1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu_13", last_rdata, 32'h0000_0080);
        access(1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_10_after_sb", last_rdata, 32'h80AD_BEEF);

        // Misaligned accesses fault with no side effect.
        access(1'b0, 3'b001, 32'h11, 32'h0);
        chk("lh_mis_latency", 32'(last_done_cyc - req_cyc), 32'd1);
        chk("lh_mis_fault", last_fault, 1'b1);
        chk("lh_mis_rdata", last_rdata, 32'h0);
        access(1'b1, 3'b010, 32'h12, 32'h1234_5678);
        access(1'b0, 3'b011, 32'h10, 32'h0);
        chk("f3_011_as_w", last_rdata, 32'h80AD_BEEF);
        access(1'b0, 3'b110, 32'h12, 32'h0);
        chk("f3_110_mis", last_fault, 1'b1);

        // Halfword lanes.
        access(1'b1, 3'b001, 32'h16, 32'hFFFF_8001);
        access(1'b0, 3'b001, 32'h16, 32'h0);
        chk("lh_16", last_rdata, 32'hFFFF_8001);
        access(1'b0, 3'b101, 32'h16, 32'h0);
        chk("lhu_16", last_rdata, 32'h0000_8001);

        // DMEM upper boundary and out-of-range decode.
        access(1'b1, 3'b010, 32'h0, 32'h0);
        access(1'b1, 3'b010, 32'hFFC, 32'hCAFE_F00D);
        access(1'b1, 3'b010, 32'h1000, 32'h1111_1111);
        access(1'b0, 3'b010, 32'h1000, 32'h0);
        chk("lw_oob", last_rdata, 32'h0);
        access(1'b0, 3'b010, 32'h0, 32'h0);
        chk("lw_0_no_alias", last_rdata, 32'h0);
        access(1'b0, 3'b010, 32'hFFC, 32'h0);
        chk("lw_top", last_rdata, 32'hCAFE_F00D);
        access(1'b1, 3'b010, 32'h2000_0000, 32'hFFFF_FFFF);
        access(1'b0, 3'b010, 32'h2000_0000, 32'h0);
        chk("lw_other", last_rdata, 32'h0);

        // UART frame, STATUS while busy, queued second frame.
        access(1'b1, 3'b000, UB, 32'h0000_0055);
        s1 = req_cyc + 1;
        chk("uart_sb_latency", 32'(last_done_cyc - req_cyc), 32'd1);
        idle(3);
        access(1'b0, 3'b010, UB + 32'd4, 32'h0);
        chk("status_busy", last_rdata, 32'h1);
        access(1'b0, 3'b010, UB, 32'h0);
        chk("txdata_load", last_rdata, 32'h0);
        access(1'b1, 3'b010, UB + 32'd4, 32'h0000_00AA);
        idle(2);
        r2 = cyc;
        access(1'b1, 3'b000, UB, 32'h0000_00A3);
        chk("uwait_done", 32'(last_done_cyc), 32'(s1 + 10 * B));
        chk("uwait_held", 32'(last_done_cyc - r2) > 32'd10, 1'b1);
        while (cyc < tx_end + 2) idle(1);
        pat = 10'b10_1010_1010;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < B; j++) chk("frame55", txd_log[s1 + k*B + j], pat[k]);
        end
        chk("frame2_start", txd_log[s1 + 10*B], 1'b0);
        chk("frame1_stop", txd_log[s1 + 10*B - 1], 1'b1);
        access(1'b0, 3'b010, UB + 32'd4, 32'h0);
        chk("status_idle", last_rdata, 32'h0);

        // Reset during a DRD load while a UART frame is running.
        access(1'b1, 3'b000, UB, 32'h0000_005A);
        idle(5);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        do_reset();
        idle(2);
        access(1'b0, 3'b010, UB + 32'd4, 32'h0);
        chk("status_after_rst", last_rdata, 32'h0);
        access(1'b0, 3'b010, 32'h10, 32'h0);
        chk("bram_kept", last_rdata, 32'h80AD_BEEF);
        idle(3);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
